// File: rtl/mips_div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU feeding the LO/HI stage.
// Optional build macro DIV_ZERO_FAST_EN adds a div_zero flag and a single-cycle zero-divisor path.
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] div_hi,
`ifdef DIV_ZERO_FAST_EN
  output logic             div_zero,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
`ifdef DIV_ZERO_FAST_EN
  logic             div_zero_q, div_zero_d;
`endif

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             trial_ok;

  always_comb begin
    dvd_neg   = is_signed & dividend[WIDTH-1];
    dvs_neg   = is_signed & divisor[WIDTH-1];
    dvd_abs   = dvd_neg ? -dividend : dividend;
    dvs_abs   = dvs_neg ? -divisor : divisor;
    // The shifted remainder needs WIDTH+1 bits; the subtraction result always fits in WIDTH.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial_ok  = (rem_shift >= {1'b0, dvs_q});
    trial     = rem_shift[WIDTH-1:0] - dvs_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef DIV_ZERO_FAST_EN
    div_zero_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            lo_d       = '1;
            hi_d       = dividend;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
`endif
            rem_d   = '0;
            quo_d   = dvd_abs;
            dvs_d   = dvs_abs;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
          end
`endif
        end
      end
      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        rem_d = trial_ok ? trial : rem_shift[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = q_neg_q ? -quo_q : quo_q;
        hi_d    = r_neg_q ? -rem_q : rem_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts from any state and leaves the last completed result visible.
    if (flush) begin
      state_d = S_IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
`ifdef DIV_ZERO_FAST_EN
      div_zero_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef DIV_ZERO_FAST_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef DIV_ZERO_FAST_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign div_lo    = lo_q;
  assign div_hi    = hi_q;
  assign dbg_state = state_q;
`ifdef DIV_ZERO_FAST_EN
  assign div_zero  = div_zero_q;
`endif

endmodule
